mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: bus_ack wait limit in cycles before timeout.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  in  1  fetch request, level, held until if_ack.
REQ-005 SHALL have port if_addr  in  32  fetch byte address.
REQ-006 SHALL have port if_rdata  out  32  fetched word, valid with if_ack.
REQ-007 SHALL have port if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dm_req  in  1  data request, level, held until dm_ack.
REQ-009 SHALL have port dm_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port dm_be  in  4  store byte enables.
REQ-011 SHALL have port dm_addr  in  32  data byte address.
REQ-012 SHALL have port dm_wdata  in  32  store data.
REQ-013 SHALL have port dm_rdata  out  32  load data, valid with dm_ack.
REQ-014 SHALL have port dm_ack  out  1  one-cycle data completion pulse.
REQ-015 SHALL have port bus_req  out  1  registered request to the single memory port.
REQ-016 SHALL have port bus_we  out  1  registered write strobe.
REQ-017 SHALL have port bus_be  out  4  registered byte enables (4'b1111 for fetch).
REQ-018 SHALL have port bus_addr  out  32  registered address.
REQ-019 SHALL have port bus_wdata  out  32  registered write data.
REQ-020 SHALL have port bus_rdata  in  32  memory read data, valid with bus_ack.
REQ-021 SHALL have port bus_ack  in  1  memory completion; may rise in the same cycle as bus_req.
REQ-022 SHALL have port mem_stall  out  1  pipeline-wide stall to the control unit.
REQ-023 SHALL have port arb_err  out  1  timeout flag, pulses with the affected ack.
Function
REQ-024 SHALL use FSM states IDLE, BUS_I, BUS_D, RESP.
REQ-025 IDLE: grant on pending requests; next state BUS_I or BUS_D; latch addr/we/be/wdata into bus registers.
REQ-026 Both pending in IDLE: grant the requester not granted last (round robin); last_grant resets to I, so data wins first.
REQ-027 BUS_x: hold bus_req and all bus fields stable until bus_ack; on bus_ack capture bus_rdata, drop bus_req, go RESP.
REQ-028 RESP: pulse if_ack or dm_ack for exactly one cycle with captured data; go IDLE; update last_grant.
REQ-029 Minimum latency: req seen cycle 0, bus_req cycle 1, bus_ack cycle 1, requester ack cycle 2; new request seen earliest cycle 3.
REQ-030 Fetch bus cycles SHALL drive bus_we=0, bus_be=4'b1111, bus_wdata=0.
REQ-031 mem_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
REQ-032 Granted requester dropping req during BUS_x (pipeline flush): bus transaction completes; no ack issued; data discarded.
REQ-033 Wait counter clears on entering BUS_x, increments each cycle without bus_ack; at MAX_WAIT: drop bus_req, RESP with rdata=0 and arb_err=1.
REQ-034 bus_ack SHALL be ignored in IDLE and RESP.
REQ-035 Ungranted requester's inputs SHALL not affect bus outputs until its grant.
Reset
REQ-036 On reset: state IDLE, last_grant=I, counter 0; bus_req, bus_we, if_ack, dm_ack, arb_err = 0; bus_be, bus_addr, bus_wdata, if_rdata, dm_rdata = 0.
REQ-037 Reset mid-transaction: bus_req deasserts next cycle; no ack issued; outstanding transaction abandoned.
Structure
REQ-038 State encoding, grant encoding (GNT_I, GNT_D), and fetch byte-enable constant SHALL live in shared package mem_arb_pkg.
REQ-039 Wait counter SHALL be sub-module mem_arb_timer (clear, count, expired at MAX_WAIT).
Verification
REQ-040 if_req=1, if_addr=0x00400000, bus_ack same cycle, bus_rdata=0x24080001 -> if_ack at cycle 2, if_rdata=0x24080001, mem_stall 1 in cycles 0-1.
REQ-041 if_req and dm_req (store, addr 0x10010004, be 4'b0011, wdata 0xBEEF) both rise at cycle 0 after reset -> data served first with bus_we=1, bus_be=4'b0011; fetch served next.
REQ-042 Both requests held continuously -> grants alternate D, I, D, I.
REQ-043 if_req drops while BUS_I with bus_ack delayed 3 cycles -> bus_req held to bus_ack, no if_ack issued.
REQ-044 MAX_WAIT=4, bus_ack never asserted -> bus_req drops after 4 cycles; dm_ack with arb_err=1 and dm_rdata=0.
REQ-045 reset asserted in BUS_D -> next cycle bus_req=0, state IDLE, no dm_ack.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   state_t  : arbiter FSM states (IDLE, BUS_I, BUS_D, RESP)
//   grant_t  : which requester owns the memory port (GNT_I fetch, GNT_D data)
//   FETCH_BE : byte enables driven for every instruction fetch
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam logic [3:0] FETCH_BE = 4'b1111;

  // Round-robin pick when both requesters are pending: the one not served last.
  function automatic grant_t rr_pick(input grant_t last_grant);
    return (last_grant == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus wait counter for the memory arbiter.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the counter (new bus transaction starts)
//   count_en   : this cycle is a bus cycle without bus_ack
//   expired    : this is the MAX_WAIT-th unacknowledged bus cycle; the
//                arbiter abandons the transaction at the end of it
module mem_arb_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of waiting cycles already elapsed, so the
  // current cycle is number count+1; expiry fires on cycle MAX_WAIT so
  // bus_req stays high for exactly MAX_WAIT cycles.
  assign expired = count_en && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data access.
//   clk, reset        : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request (level) and byte address
//   if_rdata/if_ack   : fetched word and one-cycle completion pulse
//   dm_req/we/be/addr/wdata : data request (level) and store fields
//   dm_rdata/dm_ack   : load data and one-cycle completion pulse
//   bus_req/we/be/addr/wdata : registered memory request
//   bus_rdata/bus_ack : memory response (ack may coincide with first bus_req cycle)
//   mem_stall         : pipeline stall while any request is unanswered
//   arb_err           : pulses with the ack of a timed-out transaction
//   dbg_state         : current FSM state
//
// Handshake: a requester raises req with stable fields and holds it until
// its ack pulse; the cycle carrying ack also carries valid rdata. On the
// memory side bus_req and all bus fields stay constant from issue until the
// cycle in which bus_ack is seen (or the wait limit is reached).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic        arb_err,
  output state_t      dbg_state
);

  state_t state, state_next;
  grant_t grant, grant_next;
  grant_t last_grant;

  logic start;      // IDLE hands the port to grant_next this cycle
  logic finish;     // bus transaction ends this cycle (ack or timeout)
  logic timeout;    // ... and it ended by timeout
  logic in_bus;
  logic gnt_req;    // live request level of the current owner
  logic keep;       // owner has held req for the whole transaction so far
  logic deliver;    // owner still wants the result at finish
  logic expired;

  assign in_bus    = (state == BUS_I) || (state == BUS_D);
  assign gnt_req   = (grant == GNT_I) ? if_req : dm_req;
  // A requester that lets go of req (pipeline flush) forfeits the result,
  // even if it raises req again before the bus completes.
  assign deliver   = keep && gnt_req;
  assign mem_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);
  assign dbg_state = state;

  mem_arb_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .count_en (in_bus && !bus_ack),
    .expired  (expired)
  );

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    grant_next = grant;
    start      = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (if_req && dm_req) begin
          grant_next = rr_pick(last_grant);
        end else if (dm_req) begin
          grant_next = GNT_D;
        end else if (if_req) begin
          grant_next = GNT_I;
        end
        if (if_req || dm_req) begin
          start      = 1'b1;
          state_next = (grant_next == GNT_I) ? BUS_I : BUS_D;
        end
      end
      BUS_I, BUS_D: begin
        // A real ack in the final allowed cycle still wins over the timeout.
        if (bus_ack) begin
          finish     = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          finish     = 1'b1;
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus registered bus and response datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= GNT_I;
      last_grant <= GNT_I;
      keep       <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_be     <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      arb_err    <= 1'b0;
    end else begin
      state   <= state_next;
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      arb_err <= 1'b0;

      if (start) begin
        grant   <= grant_next;
        keep    <= 1'b1;
        bus_req <= 1'b1;
        if (grant_next == GNT_D) begin
          bus_we    <= dm_we;
          bus_be    <= dm_be;
          bus_addr  <= dm_addr;
          bus_wdata <= dm_wdata;
        end else begin
          bus_we    <= 1'b0;
          bus_be    <= FETCH_BE;
          bus_addr  <= if_addr;
          bus_wdata <= '0;
        end
      end

      if (in_bus) begin
        keep <= deliver;
      end

      if (finish) begin
        bus_req <= 1'b0;
        if (deliver) begin
          arb_err <= timeout;
          if (grant == GNT_I) begin
            if_ack   <= 1'b1;
            if_rdata <= timeout ? 32'h0 : bus_rdata;
          end else begin
            dm_ack   <= 1'b1;
            dm_rdata <= timeout ? 32'h0 : bus_rdata;
          end
        end
      end

      if (state == RESP) begin
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_WAIT = 4). Inputs change 1 time unit
// after each rising edge; outputs are checked on the falling edge. "Cycle n"
// is the clock period in which the inputs for step n are presented.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        mem_stall;
  logic        arb_err;
  state_t      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .mem_stall (mem_stall),
    .arb_err   (arb_err),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_be     = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    n_checks++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req: got %0b want 0", bus_req); else n_pass++;
    n_checks++; if ({if_ack, dm_ack, arb_err, bus_we} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {if_ack, dm_ack, arb_err, bus_we}); else n_pass++;
    n_checks++; if ({bus_be, bus_addr, bus_wdata} !== 68'h0) $display("FAIL reset_bus_fields: got be=%h addr=%h wdata=%h want 0", bus_be, bus_addr, bus_wdata); else n_pass++;
    n_checks++; if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h %h want 0", if_rdata, dm_rdata); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", mem_stall); else n_pass++;
  endtask

  // Minimum-latency fetch: req cycle 0, bus_req and bus_ack cycle 1, if_ack cycle 2.
  task automatic test_fetch();
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    sample();
    n_checks++; if ({mem_stall, bus_req} !== 2'b10) $display("FAIL fetch_c0: got stall=%0b bus_req=%0b want 1 0", mem_stall, bus_req); else n_pass++;
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h2408_0001;
    sample();
    n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0040_0000) $display("FAIL fetch_c1_bus: got req=%0b addr=%h want 1 00400000", bus_req, bus_addr); else n_pass++;
    n_checks++; if ({bus_we, bus_be, bus_wdata} !== {1'b0, 4'hF, 32'h0}) $display("FAIL fetch_c1_fields: got we=%0b be=%h wdata=%h want 0 f 0", bus_we, bus_be, bus_wdata); else n_pass++;
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL fetch_c1_stall: got %0b want 1", mem_stall); else n_pass++;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    sample();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h2408_0001) $display("FAIL fetch_c2_ack: got ack=%0b rdata=%h want 1 24080001", if_ack, if_rdata); else n_pass++;
    n_checks++; if ({mem_stall, bus_req, dm_ack, arb_err} !== 4'b0) $display("FAIL fetch_c2_misc: got %b want 0000", {mem_stall, bus_req, dm_ack, arb_err}); else n_pass++;
    step();
    if_req = 1'b0;
    sample();
    n_checks++; if (if_ack !== 1'b0 || dbg_state !== IDLE) $display("FAIL fetch_c3: got ack=%0b state=%0d want 0 IDLE", if_ack, dbg_state); else n_pass++;
  endtask

  // Simultaneous requests after reset: data first (store), then fetch.
  task automatic test_both_pending();
    do_reset();
    if_req   = 1'b1;
    if_addr  = 32'h0040_0004;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0011;
    dm_addr  = 32'h1001_0004;
    dm_wdata = 32'h0000_BEEF;
    step();
    // Change the ungranted fetch address while data owns the bus.
    if_addr = 32'h0040_0008;
    sample();
    n_checks++; if ({bus_req, bus_we, bus_be} !== 6'b1_1_0011) $display("FAIL both_d_ctrl: got req=%0b we=%0b be=%b want 1 1 0011", bus_req, bus_we, bus_be); else n_pass++;
    n_checks++; if (bus_addr !== 32'h1001_0004 || bus_wdata !== 32'h0000_BEEF) $display("FAIL both_d_data: got addr=%h wdata=%h want 10010004 0000beef", bus_addr, bus_wdata); else n_pass++;
    step();
    bus_ack = 1'b1;
    sample();
    n_checks++; if (bus_addr !== 32'h1001_0004 || bus_req !== 1'b1) $display("FAIL both_d_stable: got addr=%h req=%0b want 10010004 1", bus_addr, bus_req); else n_pass++;
    step();
    bus_ack = 1'b0;
    sample();
    n_checks++; if ({dm_ack, if_ack} !== 2'b10) $display("FAIL both_d_ack: got dm=%0b if=%0b want 1 0", dm_ack, if_ack); else n_pass++;
    step();
    dm_req = 1'b0;
    sample();
    n_checks++; if (dbg_state !== IDLE || bus_req !== 1'b0) $display("FAIL both_idle: got state=%0d req=%0b want IDLE 0", dbg_state, bus_req); else n_pass++;
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    sample();
    n_checks++; if ({bus_req, bus_we, bus_be} !== 6'b1_0_1111 || bus_addr !== 32'h0040_0008 || bus_wdata !== 32'h0) $display("FAIL both_i_bus: got req=%0b we=%0b be=%b addr=%h wdata=%h want 1 0 1111 00400008 0", bus_req, bus_we, bus_be, bus_addr, bus_wdata); else n_pass++;
    step();
    bus_ack = 1'b0;
    sample();
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h1234_5678 || dm_ack !== 1'b0) $display("FAIL both_i_ack: got ack=%0b rdata=%h dm_ack=%0b want 1 12345678 0", if_ack, if_rdata, dm_ack); else n_pass++;
    step();
    if_req = 1'b0;
  endtask

  // Both requests held throughout: grants alternate D, I, D, I.
  task automatic test_alternate();
    logic [3:0] exp_d;
    exp_d = 4'b0101;  // bit t = 1 means transaction t goes to data
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0000_1000;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'b1111;
    dm_addr = 32'h0000_2000;
    for (int t = 0; t < 4; t++) begin
      sample();
      n_checks++; if (dbg_state !== IDLE) $display("FAIL alt_idle_%0d: got %0d want IDLE", t, dbg_state); else n_pass++;
      step();
      bus_ack   = 1'b1;
      bus_rdata = 32'hA000_0000 + t;
      sample();
      n_checks++; if (bus_addr !== (exp_d[t] ? 32'h0000_2000 : 32'h0000_1000)) $display("FAIL alt_grant_%0d: got addr=%h want %h", t, bus_addr, exp_d[t] ? 32'h0000_2000 : 32'h0000_1000); else n_pass++;
      step();
      bus_ack = 1'b0;
      sample();
      n_checks++; if ({dm_ack, if_ack} !== (exp_d[t] ? 2'b10 : 2'b01)) $display("FAIL alt_ack_%0d: got dm=%0b if=%0b want d=%0b", t, dm_ack, if_ack, exp_d[t]); else n_pass++;
      step();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
  endtask

  // Fetch flushed while the bus waits; ack arrives on the last allowed cycle.
  task automatic test_flush();
    int acks;
    acks = 0;
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h0040_0100;
    step();
    if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      if (if_ack === 1'b1) acks++;
      n_checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h0040_0100) $display("FAIL flush_hold_%0d: got req=%0b addr=%h want 1 00400100", c, bus_req, bus_addr); else n_pass++;
      step();
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    sample();
    n_checks++; if (bus_req !== 1'b1 || mem_stall !== 1'b0) $display("FAIL flush_c4: got req=%0b stall=%0b want 1 0", bus_req, mem_stall); else n_pass++;
    step();
    bus_ack = 1'b0;
    sample();
    if (if_ack === 1'b1) acks++;
    n_checks++; if (bus_req !== 1'b0 || dbg_state !== RESP || arb_err !== 1'b0) $display("FAIL flush_c5: got req=%0b state=%0d err=%0b want 0 RESP 0", bus_req, dbg_state, arb_err); else n_pass++;
    step();
    sample();
    if (if_ack === 1'b1) acks++;
    n_checks++; if (acks != 0 || if_rdata !== 32'h0) $display("FAIL flush_no_ack: got acks=%0d rdata=%h want 0 0", acks, if_rdata); else n_pass++;
  endtask

  // Load completes, then a second load times out after 4 bus cycles.
  task automatic test_timeout();
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'b1111;
    dm_addr = 32'h0000_0100;
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'hDEAD_BEEF;
    sample();
    n_checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'hCAFE_F00D) $display("FAIL tmo_first: got ack=%0b rdata=%h want 1 cafef00d", dm_ack, dm_rdata); else n_pass++;
    step();
    dm_addr = 32'h0000_0104;
    step();
    for (int c = 1; c <= 4; c++) begin
      sample();
      n_checks++; if (bus_req !== 1'b1 || dm_ack !== 1'b0) $display("FAIL tmo_wait_%0d: got req=%0b ack=%0b want 1 0", c, bus_req, dm_ack); else n_pass++;
      step();
    end
    sample();
    n_checks++; if (bus_req !== 1'b0) $display("FAIL tmo_drop: got %0b want 0", bus_req); else n_pass++;
    n_checks++; if ({dm_ack, arb_err} !== 2'b11 || dm_rdata !== 32'h0) $display("FAIL tmo_resp: got ack=%0b err=%0b rdata=%h want 1 1 0", dm_ack, arb_err, dm_rdata); else n_pass++;
    step();
    dm_req = 1'b0;
    sample();
    n_checks++; if ({dm_ack, arb_err} !== 2'b00) $display("FAIL tmo_after: got ack=%0b err=%0b want 0 0", dm_ack, arb_err); else n_pass++;
  endtask

  // Reset while a store waits on the bus: transaction abandoned.
  task automatic test_reset_mid();
    do_reset();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b1100;
    dm_addr  = 32'h1001_0010;
    dm_wdata = 32'h7777_0000;
    step();
    sample();
    n_checks++; if (dbg_state !== BUS_D || bus_req !== 1'b1) $display("FAIL rmid_bus: got state=%0d req=%0b want BUS_D 1", dbg_state, bus_req); else n_pass++;
    reset = 1'b1;
    step();
    dm_req  = 1'b0;
    bus_ack = 1'b1;
    sample();
    n_checks++; if (bus_req !== 1'b0 || dbg_state !== IDLE || dm_ack !== 1'b0) $display("FAIL rmid_after: got req=%0b state=%0d ack=%0b want 0 IDLE 0", bus_req, dbg_state, dm_ack); else n_pass++;
    reset = 1'b0;
    step();
    bus_ack = 1'b0;
    sample();
    n_checks++; if (dm_ack !== 1'b0 || bus_req !== 1'b0) $display("FAIL rmid_quiet: got ack=%0b req=%0b want 0 0", dm_ack, bus_req); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_both_pending();
    test_alternate();
    test_flush();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
